// File: rtl/player_pkg.sv
// Shared types and playfield defaults for the player motion controller.
package player_pkg;

  typedef enum logic [1:0] {
    DIR_IDLE = 2'd0,
    DIR_NEG  = 2'd1,
    DIR_POS  = 2'd2
  } dir_t;

  typedef enum logic [1:0] {
    AX_IDLE = 2'd0,
    AX_SLOW = 2'd1,
    AX_FAST = 2'd2
  } axis_state_t;

  localparam int DEF_PLAYER_RADIUS = 35;
  localparam int DEF_X_LO          = 2;
  localparam int DEF_X_HI          = 638;
  localparam int DEF_Y_LO          = 2;
  localparam int DEF_Y_HI          = 510;

  // Opposing or absent requests cancel out to idle.
  function automatic dir_t decode_dir(input logic req_neg, input logic req_pos);
    case ({req_neg, req_pos})
      2'b10:   return DIR_NEG;
      2'b01:   return DIR_POS;
      default: return DIR_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/player_axis_stepper.sv
// One motion axis: direction decode, IDLE/SLOW/FAST FSM, tick and step counters,
// and a position register clamped to [LO, HI].
module player_axis_stepper
  import player_pkg::*;
#(
  parameter int POS_WIDTH   = 10,
  parameter int LO          = 37,
  parameter int HI          = 603,
  parameter int INIT        = 320,
  parameter int SLOW_PERIOD = 100000,
  parameter int FAST_PERIOD = 25000,
  parameter int ACCEL_STEPS = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_neg,
  input  logic                 req_pos,
  input  logic                 freeze,
  input  logic                 respawn,
  output logic [POS_WIDTH-1:0] pos,
  output logic                 moving
);

  localparam int CNT_W  = (SLOW_PERIOD > 1) ? $clog2(SLOW_PERIOD) : 1;
  localparam int STEP_W = (ACCEL_STEPS > 0) ? $clog2(ACCEL_STEPS + 1) : 1;
  localparam bit ACCEL_EN = (ACCEL_STEPS > 0);
  localparam logic [CNT_W-1:0]     SLOW_LAST = CNT_W'(SLOW_PERIOD - 1);
  localparam logic [CNT_W-1:0]     FAST_LAST = CNT_W'(FAST_PERIOD - 1);
  localparam logic [STEP_W-1:0]    STEP_MAX  = STEP_W'(ACCEL_STEPS);
  localparam logic [POS_WIDTH-1:0] POS_LO    = POS_WIDTH'(LO);
  localparam logic [POS_WIDTH-1:0] POS_HI    = POS_WIDTH'(HI);
  localparam logic [POS_WIDTH-1:0] POS_INIT  = POS_WIDTH'(INIT);

  axis_state_t          state_reg, state_next;
  dir_t                 dir_reg, dir_next, dir_req;
  logic [CNT_W-1:0]     cnt_reg, cnt_next, cnt_last;
  logic [STEP_W-1:0]    steps_reg, steps_next, steps_inc;
  logic [POS_WIDTH-1:0] pos_reg, pos_next;
  logic                 moving_reg, moving_next;
  logic                 running, tick, accel_now, can_move;

  // Motion continues only while the request matches the latched direction.
  assign dir_req   = decode_dir(req_neg, req_pos);
  assign running   = (state_reg != AX_IDLE) && (dir_req == dir_reg);
  assign cnt_last  = (state_reg == AX_FAST) ? FAST_LAST : SLOW_LAST;
  assign tick      = running && (cnt_reg == cnt_last);
  assign steps_inc = (steps_reg == STEP_MAX) ? steps_reg : steps_reg + 1'b1;
  assign accel_now = ACCEL_EN && tick && (state_reg == AX_SLOW) && (steps_inc == STEP_MAX);
  assign can_move  = (dir_reg == DIR_NEG) ? (pos_reg > POS_LO) : (pos_reg < POS_HI);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg  <= AX_IDLE;
      dir_reg    <= DIR_IDLE;
      cnt_reg    <= '0;
      steps_reg  <= '0;
      pos_reg    <= POS_INIT;
      moving_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      dir_reg    <= dir_next;
      cnt_reg    <= cnt_next;
      steps_reg  <= steps_next;
      pos_reg    <= pos_next;
      moving_reg <= moving_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    dir_next   = dir_reg;
    if (respawn) begin
      state_next = AX_IDLE;
      dir_next   = DIR_IDLE;
    end else if (!freeze) begin
      case (state_reg)
        AX_IDLE: begin
          if (dir_req != DIR_IDLE) begin
            state_next = AX_SLOW;
            dir_next   = dir_req;
          end
        end
        default: begin
          if (!running) begin
            state_next = AX_IDLE;
            dir_next   = DIR_IDLE;
          end else if (accel_now) begin
            state_next = AX_FAST;
          end
        end
      endcase
    end
  end

  // A blocked step still restarts the period and counts toward acceleration.
  always_comb begin
    cnt_next    = cnt_reg;
    steps_next  = steps_reg;
    pos_next    = pos_reg;
    moving_next = 1'b0;
    if (respawn) begin
      cnt_next   = '0;
      steps_next = '0;
      pos_next   = POS_INIT;
    end else if (!freeze) begin
      if (!running) begin
        cnt_next   = '0;
        steps_next = '0;
      end else if (tick) begin
        cnt_next   = '0;
        steps_next = steps_inc;
        if (can_move) begin
          pos_next    = (dir_reg == DIR_NEG) ? pos_reg - 1'b1 : pos_reg + 1'b1;
          moving_next = 1'b1;
        end
      end else begin
        cnt_next = cnt_reg + 1'b1;
      end
    end
  end

  assign pos    = pos_reg;
  assign moving = moving_reg;

endmodule

// File: rtl/player_motion_controller.sv
// Two-axis player position controller: button synchronizers, two axis steppers
// sharing freeze/respawn, and the playfield edge decode.
module player_motion_controller
  import player_pkg::*;
#(
  parameter int POS_WIDTH     = 10,
  parameter int PLAYER_RADIUS = DEF_PLAYER_RADIUS,
  parameter int X_LO          = DEF_X_LO,
  parameter int X_HI          = DEF_X_HI,
  parameter int Y_LO          = DEF_Y_LO,
  parameter int Y_HI          = DEF_Y_HI,
  parameter int INIT_X        = 320,
  parameter int INIT_Y        = 200,
  parameter int SLOW_PERIOD   = 100000,
  parameter int FAST_PERIOD   = 25000,
  parameter int ACCEL_STEPS   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 up_btn_n,
  input  logic                 down_btn_n,
  input  logic                 left_btn_n,
  input  logic                 right_btn_n,
  input  logic                 freeze,
  input  logic                 respawn,
  output logic [POS_WIDTH-1:0] x_pos,
  output logic [POS_WIDTH-1:0] y_pos,
  output logic [1:0]           moving,
  output logic [3:0]           at_edge
);

  localparam int X_MIN = X_LO + PLAYER_RADIUS;
  localparam int X_MAX = X_HI - PLAYER_RADIUS;
  localparam int Y_MIN = Y_LO + PLAYER_RADIUS;
  localparam int Y_MAX = Y_HI - PLAYER_RADIUS;

  if (INIT_X < X_MIN || INIT_X > X_MAX) begin : g_bad_init_x
    $error("INIT_X outside legal x range");
  end
  if (INIT_Y < Y_MIN || INIT_Y > Y_MAX) begin : g_bad_init_y
    $error("INIT_Y outside legal y range");
  end
  if (SLOW_PERIOD < 2 || FAST_PERIOD < 2 || FAST_PERIOD > SLOW_PERIOD) begin : g_bad_period
    $error("periods must satisfy 2 <= FAST_PERIOD <= SLOW_PERIOD");
  end

  logic [3:0] btn_n;
  logic [3:0] req;
  logic       moving_x, moving_y;

  // Bit order {up, down, left, right}, matching at_edge.
  assign btn_n = {up_btn_n, down_btn_n, left_btn_n, right_btn_n};

  genvar gi;
  for (gi = 0; gi < 4; gi++) begin : g_sync
    logic sync1_reg, sync2_reg;
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        sync1_reg <= 1'b1;
        sync2_reg <= 1'b1;
      end else begin
        sync1_reg <= btn_n[gi];
        sync2_reg <= sync1_reg;
      end
    end
    assign req[gi] = ~sync2_reg;
  end

  player_axis_stepper #(
    .POS_WIDTH(POS_WIDTH), .LO(X_MIN), .HI(X_MAX), .INIT(INIT_X),
    .SLOW_PERIOD(SLOW_PERIOD), .FAST_PERIOD(FAST_PERIOD), .ACCEL_STEPS(ACCEL_STEPS)
  ) u_axis_x (
    .clk(clk), .rst_n(rst_n), .req_neg(req[1]), .req_pos(req[0]),
    .freeze(freeze), .respawn(respawn), .pos(x_pos), .moving(moving_x)
  );

  player_axis_stepper #(
    .POS_WIDTH(POS_WIDTH), .LO(Y_MIN), .HI(Y_MAX), .INIT(INIT_Y),
    .SLOW_PERIOD(SLOW_PERIOD), .FAST_PERIOD(FAST_PERIOD), .ACCEL_STEPS(ACCEL_STEPS)
  ) u_axis_y (
    .clk(clk), .rst_n(rst_n), .req_neg(req[3]), .req_pos(req[2]),
    .freeze(freeze), .respawn(respawn), .pos(y_pos), .moving(moving_y)
  );

  assign moving = {moving_y, moving_x};

  assign at_edge = {y_pos == POS_WIDTH'(Y_MIN), y_pos == POS_WIDTH'(Y_MAX),
                    x_pos == POS_WIDTH'(X_MIN), x_pos == POS_WIDTH'(X_MAX)};

endmodule

// File: tb/tb_player_motion_controller.sv
// Randomized bench for player_motion_controller against a step-schedule reference model.
module tb_player_motion_controller;

  localparam int SLOW = 4, FAST = 2, ACCEL = 3, INIT_X = 100, INIT_Y = 100, R = 35;
  localparam int X_MIN = 2 + R, X_MAX = 638 - R, Y_MIN = 2 + R, Y_MAX = 510 - R;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       up_n = 1'b1, down_n = 1'b1, left_n = 1'b1, right_n = 1'b1;
  logic       freeze = 1'b0, respawn = 1'b0;
  logic [9:0] x_pos, y_pos;
  logic [1:0] moving;
  logic [3:0] at_edge;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: button history plus, per axis (0 = x, 1 = y), the run state
  // expressed as cycles elapsed since motion started.
  logic [3:0] h1 = 4'hF, h2 = 4'hF;
  int m_pos[2];
  bit m_run[2];
  int m_dir[2];
  int m_cyc[2];
  bit m_mov[2];

  always #5 clk = ~clk;

  player_motion_controller #(
    .SLOW_PERIOD(SLOW), .FAST_PERIOD(FAST), .ACCEL_STEPS(ACCEL),
    .INIT_X(INIT_X), .INIT_Y(INIT_Y)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .up_btn_n(up_n), .down_btn_n(down_n), .left_btn_n(left_n), .right_btn_n(right_n),
    .freeze(freeze), .respawn(respawn),
    .x_pos(x_pos), .y_pos(y_pos), .moving(moving), .at_edge(at_edge)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, obs, exp);
    end
  endtask

  // Steps land at multiples of SLOW for the first ACCEL steps, then every FAST cycles.
  function automatic bit step_due(input int n);
    if (ACCEL == 0 || n <= SLOW * ACCEL) return (n % SLOW) == 0;
    return ((n - SLOW * ACCEL) % FAST) == 0;
  endfunction

  task automatic model_reset();
    h1 = 4'hF;
    h2 = 4'hF;
    m_pos[0] = INIT_X;
    m_pos[1] = INIT_Y;
    for (int a = 0; a < 2; a++) begin
      m_run[a] = 1'b0;
      m_dir[a] = 0;
      m_cyc[a] = 0;
      m_mov[a] = 1'b0;
    end
  endtask

  task automatic model_edge();
    logic [3:0] req;
    int want[2];
    int lo, hi, np;
    if (!rst_n) begin
      model_reset();
      return;
    end
    req = ~h2;
    want[0] = (req[1] && !req[0]) ? -1 : (req[0] && !req[1]) ? 1 : 0;
    want[1] = (req[3] && !req[2]) ? -1 : (req[2] && !req[3]) ? 1 : 0;
    h2 = h1;
    h1 = {up_n, down_n, left_n, right_n};
    for (int a = 0; a < 2; a++) begin
      m_mov[a] = 1'b0;
      lo = (a == 0) ? X_MIN : Y_MIN;
      hi = (a == 0) ? X_MAX : Y_MAX;
      if (respawn) begin
        m_pos[a] = (a == 0) ? INIT_X : INIT_Y;
        m_run[a] = 1'b0;
      end else if (!freeze) begin
        if (!m_run[a]) begin
          if (want[a] != 0) begin
            m_run[a] = 1'b1;
            m_dir[a] = want[a];
            m_cyc[a] = 0;
          end
        end else if (want[a] != m_dir[a]) begin
          m_run[a] = 1'b0;
        end else begin
          m_cyc[a]++;
          if (step_due(m_cyc[a])) begin
            np = m_pos[a] + m_dir[a];
            if (np >= lo && np <= hi) begin
              m_pos[a] = np;
              m_mov[a] = 1'b1;
            end
          end
        end
      end
    end
  endtask

  task automatic check_outputs();
    check_val("x_pos", x_pos, m_pos[0]);
    check_val("y_pos", y_pos, m_pos[1]);
    check_val("moving", moving, {m_mov[1], m_mov[0]});
    check_val("at_edge", at_edge, {m_pos[1] == Y_MIN, m_pos[1] == Y_MAX,
                                   m_pos[0] == X_MIN, m_pos[0] == X_MAX});
  endtask

  task automatic run_cycle();
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
    @(negedge clk);
  endtask

  task automatic hold(input logic [3:0] btns, input int cycles);
    {up_n, down_n, left_n, right_n} = btns;
    for (int i = 0; i < cycles; i++) run_cycle();
  endtask

  initial begin
    model_reset();
    run_cycle();
    run_cycle();
    rst_n = 1'b1;
    check_val("rst_x", x_pos, 100);
    check_val("rst_y", y_pos, 100);
    check_val("rst_moving", moving, 0);
    check_val("rst_edge", at_edge, 0);

    // Hold down: first y change 7 edges after the press.
    down_n = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      run_cycle();
      if (i == 6) check_val("first_step_before", y_pos, 100);
      if (i == 7) check_val("first_step_at", y_pos, 101);
    end

    hold(4'b0011, 30);   // up and down together cancel
    hold(4'b1011, 20);   // release up: down resumes from SLOW
    hold(4'b0101, 300);  // up+left into the top-left corner

    // Right with a freeze burst mid-period.
    {up_n, down_n, left_n, right_n} = 4'b1110;
    for (int i = 0; i < 40; i++) begin
      freeze = (i >= 22 && i < 32);
      run_cycle();
    end
    freeze = 1'b0;

    hold(4'b1010, 1300); // down+right into the bottom-right corner
    hold(4'b0111, 10);   // up away from the bottom edge

    // Respawn with buttons still held, then reset during FAST motion.
    hold(4'b0110, 30);
    respawn = 1'b1;
    run_cycle();
    respawn = 1'b0;
    check_val("respawn_x", x_pos, INIT_X);
    check_val("respawn_y", y_pos, INIT_Y);
    hold(4'b0110, 30);
    rst_n = 1'b0;
    run_cycle();
    rst_n = 1'b1;
    check_val("reset_mid_x", x_pos, INIT_X);
    check_val("reset_mid_mov", moving, 0);
    hold(4'b0110, 20);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(15) == 0) {up_n, down_n, left_n, right_n} = 4'($urandom);
      if (freeze) freeze = ($urandom_range(5) != 0);
      else        freeze = ($urandom_range(39) == 0);
      respawn = ($urandom_range(149) == 0);
      rst_n   = ($urandom_range(499) != 0);
      run_cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
